memory_stage: RTL and testbench

Memory stage of the 5-stage pipeline, sitting directly downstream of the execution unit and consuming the 76-bit EX/MEM buffer. It performs loads, stores, and multi-word stack transfers against a 16-bit word-addressed data memory. It produces the registered MEM/WB fields plus PC and flags restore pulses. It stalls the upstream pipeline while a 2- or 3-word stack transfer is in progress.

---
 rtl/memory_stage_pkg.sv | 94 +++++++++
 rtl/memory_stage_if.sv | 46 ++++
 rtl/memory_stage_data_memory.sv | 26 ++
 rtl/memory_stage.sv | 188 ++++++++++++++++++
 tb/tb_memory_stage.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the memory stage: FSM states, op classes,
// flag bit positions, EX/MEM and MEM/WB field widths and small decode helpers.
package memory_stage_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned ADDR_IN_W  = 32;
  localparam int unsigned DATA_IN_W  = 32;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned FLAGS_W    = 3;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned EXMEM_W    = 76;
  localparam int unsigned MEMWB_W    = 1 + REG_ADDR_W + WORD_W;

  localparam int unsigned FLAG_NF = 2;
  localparam int unsigned FLAG_CF = 1;
  localparam int unsigned FLAG_ZF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W2   = 2'd1,
    ST_W3   = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE     = 4'd0,
    OP_LOAD     = 4'd1,
    OP_STORE    = 4'd2,
    OP_PUSH_PC  = 4'd3,
    OP_POP_PC   = 4'd4,
    OP_PUSH_INT = 4'd5,
    OP_POP_INT  = 4'd6,
    OP_PUSH_FL  = 4'd7,
    OP_POP_FL   = 4'd8
  } op_e;

  // A write always takes precedence when MR and MW are both set.
  function automatic op_e decode_op(input logic mr, input logic mw,
                                    input logic stack_pc, input logic stack_flags);
    op_e op;
    if (mw) begin
      if (stack_pc && stack_flags) op = OP_PUSH_INT;
      else if (stack_pc)           op = OP_PUSH_PC;
      else if (stack_flags)        op = OP_PUSH_FL;
      else                         op = OP_STORE;
    end else if (mr) begin
      if (stack_pc && stack_flags) op = OP_POP_INT;
      else if (stack_pc)           op = OP_POP_PC;
      else if (stack_flags)        op = OP_POP_FL;
      else                         op = OP_LOAD;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

  function automatic logic is_multi(input op_e op);
    case (op)
      OP_PUSH_PC, OP_POP_PC, OP_PUSH_INT, OP_POP_INT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_int(input op_e op);
    case (op)
      OP_PUSH_INT, OP_POP_INT: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_write(input op_e op);
    case (op)
      OP_STORE, OP_PUSH_PC, OP_PUSH_INT, OP_PUSH_FL: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_stack_push(input op_e op);
    case (op)
      OP_PUSH_PC, OP_PUSH_INT: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] flags_word(input logic [FLAGS_W-1:0] f);
    logic [WORD_W-1:0] w;
    w          = {WORD_W{1'b0}};
    w[FLAG_NF] = f[FLAG_NF];
    w[FLAG_CF] = f[FLAG_CF];
    w[FLAG_ZF] = f[FLAG_ZF];
    return w;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// EX/MEM input bundle and MEM/WB result bundle of the memory stage.
// Mem_Fault exists only when MEM_STAGE_ADDR_CHECK_EN is defined.
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic [DATA_IN_W-1:0]  Data;
  logic [ADDR_IN_W-1:0]  Address;
  logic [REG_ADDR_W-1:0] WB_Address;
  logic                  MR;
  logic                  MW;
  logic                  WB;
  logic                  Stack_PC;
  logic                  Stack_Flags;
  logic [FLAGS_W-1:0]    Final_Flags;

  logic                  Stall;
  logic                  WB_Out;
  logic [REG_ADDR_W-1:0] WB_Address_Out;
  logic [WORD_W-1:0]     WB_Data;
  logic                  PC_Load;
  logic [PC_W-1:0]       PC_From_Stack;
  logic                  Flags_Load;
  logic [FLAGS_W-1:0]    Flags_From_Memory;
`ifdef MEM_STAGE_ADDR_CHECK_EN
  logic                  Mem_Fault;
`endif

  modport master (
`ifdef MEM_STAGE_ADDR_CHECK_EN
    input  Mem_Fault,
`endif
    output Data, Address, WB_Address, MR, MW, WB, Stack_PC, Stack_Flags, Final_Flags,
    input  Stall, WB_Out, WB_Address_Out, WB_Data, PC_Load, PC_From_Stack,
           Flags_Load, Flags_From_Memory
  );

  modport slave (
`ifdef MEM_STAGE_ADDR_CHECK_EN
    output Mem_Fault,
`endif
    input  Data, Address, WB_Address, MR, MW, WB, Stack_PC, Stack_Flags, Final_Flags,
    output Stall, WB_Out, WB_Address_Out, WB_Data, PC_Load, PC_From_Stack,
           Flags_Load, Flags_From_Memory
  );

endinterface

// File: rtl/memory_stage_data_memory.sv
// Word-addressed data memory: synchronous write port, asynchronous read port, no reset.
module data_memory #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write commits at the rising edge of the cycle the word is issued.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_stage.sv
// Memory stage: loads, stores and 1/2/3-word stack transfers with upstream stall.
// Define MEM_STAGE_ADDR_CHECK_EN to enable the upper-address fault check and Mem_Fault.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  memory_stage_if.slave bus
);

  state_e                state_q, state_d;
  logic [31:0]           hold_q, hold_d;
  logic                  wb_out_q, wb_out_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_W-1:0]     wb_data_q, wb_data_d;
  logic                  pc_load_q, pc_load_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  flags_load_q, flags_load_d;
  logic [FLAGS_W-1:0]    flags_q, flags_d;

  op_e                   op_s;
  logic [ADDR_W-1:0]     base_s, word_off_s, mem_addr_s;
  logic [WORD_W-1:0]     wdata_s, rdata_s;
  logic                  we_s, fault_s;

  assign op_s   = decode_op(bus.MR, bus.MW, bus.Stack_PC, bus.Stack_Flags);
  assign base_s = bus.Address[ADDR_W-1:0];

`ifdef MEM_STAGE_ADDR_CHECK_EN
  logic fault_q;
  // Only the first word of a transfer is range-checked.
  assign fault_s = (state_q == ST_IDLE) && (op_s != OP_NONE) &&
                   (|bus.Address[ADDR_IN_W-1:ADDR_W]);

  // Fault pulse aligned with the registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_s;
  end
  assign bus.Mem_Fault = fault_q;
`else
  logic unused_addr_hi_s;
  assign unused_addr_hi_s = ^bus.Address[ADDR_IN_W-1:ADDR_W];
  assign fault_s          = 1'b0;
`endif

  // Word address: pushes walk downwards from A, pops walk upwards.
  always_comb begin
    word_off_s = {ADDR_W{1'b0}};
    case (state_q)
      ST_W2:   word_off_s = {{(ADDR_W-1){1'b0}}, 1'b1};
      ST_W3:   word_off_s = {{(ADDR_W-2){1'b0}}, 2'd2};
      default: word_off_s = {ADDR_W{1'b0}};
    endcase
    if (is_stack_push(op_s)) mem_addr_s = base_s - word_off_s;
    else                     mem_addr_s = base_s + word_off_s;
  end

  // Write data per word of the transfer.
  always_comb begin
    wdata_s = bus.Data[15:0];
    case (op_s)
      OP_PUSH_PC, OP_PUSH_INT: begin
        case (state_q)
          ST_IDLE: wdata_s = bus.Data[31:16];
          ST_W2:   wdata_s = bus.Data[15:0];
          ST_W3:   wdata_s = flags_word(bus.Final_Flags);
          default: wdata_s = bus.Data[15:0];
        endcase
      end
      OP_PUSH_FL: wdata_s = flags_word(bus.Final_Flags);
      default:    wdata_s = bus.Data[15:0];
    endcase
  end

  assign we_s = rst_n && !fault_s && is_write(op_s);

  data_memory #(.ADDR_W(ADDR_W), .DATA_W(WORD_W)) u_data_memory (
    .clk   (clk),
    .we    (we_s),
    .addr  (mem_addr_s),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  assign bus.Stall = ((state_q == ST_IDLE) && is_multi(op_s) && !fault_s) ||
                     ((state_q == ST_W2) && is_int(op_s));

  // Next state, holding register and MEM/WB result; stalled cycles emit bubbles.
  // Holding register: [15:0] first popped word, [31:16] second word of a Pop int.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    wb_out_d     = 1'b0;
    wb_addr_d    = bus.WB_Address;
    wb_data_d    = bus.Data[15:0];
    pc_load_d    = 1'b0;
    pc_d         = pc_q;
    flags_load_d = 1'b0;
    flags_d      = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (fault_s) begin
          state_d = ST_IDLE;
        end else if (is_multi(op_s)) begin
          state_d = ST_W2;
          if (!is_write(op_s)) hold_d = {hold_q[31:16], rdata_s};
          else                 hold_d = hold_q;
        end else begin
          case (op_s)
            OP_LOAD: begin
              wb_out_d  = bus.WB;
              wb_data_d = rdata_s;
            end
            OP_POP_FL: begin
              flags_load_d = 1'b1;
              flags_d      = rdata_s[FLAGS_W-1:0];
            end
            default: wb_out_d = bus.WB;
          endcase
        end
      end
      ST_W2: begin
        if (is_int(op_s)) begin
          state_d = ST_W3;
          if (op_s == OP_POP_INT) hold_d = {rdata_s, hold_q[15:0]};
          else                    hold_d = hold_q;
        end else begin
          state_d = ST_IDLE;
          if (op_s == OP_POP_PC) begin
            pc_load_d = 1'b1;
            pc_d      = {rdata_s, hold_q[15:0]};
          end else begin
            wb_out_d = bus.WB;
          end
        end
      end
      ST_W3: begin
        state_d = ST_IDLE;
        if (op_s == OP_POP_INT) begin
          pc_load_d    = 1'b1;
          pc_d         = {rdata_s, hold_q[31:16]};
          flags_load_d = 1'b1;
          flags_d      = hold_q[FLAGS_W-1:0];
        end else begin
          wb_out_d = bus.WB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline state and registered MEM/WB outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= 32'd0;
      wb_out_q     <= 1'b0;
      wb_addr_q    <= {REG_ADDR_W{1'b0}};
      wb_data_q    <= {WORD_W{1'b0}};
      pc_load_q    <= 1'b0;
      pc_q         <= {PC_W{1'b0}};
      flags_load_q <= 1'b0;
      flags_q      <= {FLAGS_W{1'b0}};
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      wb_out_q     <= wb_out_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      pc_load_q    <= pc_load_d;
      pc_q         <= pc_d;
      flags_load_q <= flags_load_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.WB_Out            = wb_out_q;
  assign bus.WB_Address_Out    = wb_addr_q;
  assign bus.WB_Data           = wb_data_q;
  assign bus.PC_Load           = pc_load_q;
  assign bus.PC_From_Stack     = pc_q;
  assign bus.Flags_Load        = flags_load_q;
  assign bus.Flags_From_Memory = flags_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: per-cycle vector table with a scoreboard
// of expected MEM/WB results, plus reset-mid-transfer and address-fault sequences.
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memory_stage_if bus ();

  memory_stage #(.ADDR_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        mr, mw, wb, spc, sfl;
    logic [2:0]  wba;
    logic [31:0] data, addr;
    logic [2:0]  ff;
    logic        e_stall, e_wbo, e_pcl, e_fll;
    logic [15:0] e_wbd;
    logic [31:0] e_pc;
    logic [2:0]  e_fl;
  } vec_t;

  typedef struct {
    logic        wbo, pcl, fll;
    logic [2:0]  wba;
    logic [15:0] wbd;
    logic [31:0] pc;
    logic [2:0]  fl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic mr, mw, wb, spc, sfl, input logic [2:0] wba,
                     input logic [31:0] data, addr, input logic [2:0] ff,
                     input logic e_stall, e_wbo, e_pcl, e_fll,
                     input logic [15:0] e_wbd, input logic [31:0] e_pc, input logic [2:0] e_fl);
    vec_t v;
    v.mr = mr; v.mw = mw; v.wb = wb; v.spc = spc; v.sfl = sfl; v.wba = wba;
    v.data = data; v.addr = addr; v.ff = ff;
    v.e_stall = e_stall; v.e_wbo = e_wbo; v.e_pcl = e_pcl; v.e_fll = e_fll;
    v.e_wbd = e_wbd; v.e_pc = e_pc; v.e_fl = e_fl;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, check Stall, queue the expected result, compare after the edge.
  task automatic apply_vec(input vec_t v, input string tag);
    exp_t e;
    bus.MR = v.mr; bus.MW = v.mw; bus.WB = v.wb;
    bus.Stack_PC = v.spc; bus.Stack_Flags = v.sfl;
    bus.WB_Address = v.wba; bus.Data = v.data; bus.Address = v.addr; bus.Final_Flags = v.ff;
    #1;
    chk({tag, ".stall"}, {31'd0, bus.Stall}, {31'd0, v.e_stall});
    e.wbo = v.e_wbo; e.pcl = v.e_pcl; e.fll = v.e_fll;
    e.wba = v.wba; e.wbd = v.e_wbd; e.pc = v.e_pc; e.fl = v.e_fl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".wb_out"}, {31'd0, bus.WB_Out}, {31'd0, e.wbo});
    chk({tag, ".pc_load"}, {31'd0, bus.PC_Load}, {31'd0, e.pcl});
    chk({tag, ".flags_load"}, {31'd0, bus.Flags_Load}, {31'd0, e.fll});
    if (e.wbo) begin
      chk({tag, ".wb_data"}, {16'd0, bus.WB_Data}, {16'd0, e.wbd});
      chk({tag, ".wb_addr"}, {29'd0, bus.WB_Address_Out}, {29'd0, e.wba});
    end
    if (e.pcl) chk({tag, ".pc"}, bus.PC_From_Stack, e.pc);
    if (e.fll) chk({tag, ".flags"}, {29'd0, bus.Flags_From_Memory}, {29'd0, e.fl});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".wb_out"}, {31'd0, bus.WB_Out}, 32'd0);
    chk({tag, ".wb_addr"}, {29'd0, bus.WB_Address_Out}, 32'd0);
    chk({tag, ".wb_data"}, {16'd0, bus.WB_Data}, 32'd0);
    chk({tag, ".pc_load"}, {31'd0, bus.PC_Load}, 32'd0);
    chk({tag, ".pc"}, bus.PC_From_Stack, 32'd0);
    chk({tag, ".flags_load"}, {31'd0, bus.Flags_Load}, 32'd0);
    chk({tag, ".flags"}, {29'd0, bus.Flags_From_Memory}, 32'd0);
  endtask

  initial begin
    vec_t v;
    bus.MR = 1'b0; bus.MW = 1'b0; bus.WB = 1'b0; bus.Stack_PC = 1'b0; bus.Stack_Flags = 1'b0;
    bus.WB_Address = 3'd0; bus.Data = 32'd0; bus.Address = 32'd0; bus.Final_Flags = 3'd0;

    //   mr    mw    wb    spc   sfl   wba   data           addr            ff      stall wbo   pcl   fll   wbd       pc             fl
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0000_0005, 3'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h0000_0000, 32'h0000_0005, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0,         3'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h0000_5A5A, 32'h0000_0009, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h5A5A, 32'h0,         3'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_7777, 32'h0000_0007, 3'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_0000, 32'h0000_0007, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h7777, 32'h0,         3'd0);
    // Push PC then Pop PC: two cycles each, first stalled
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0001_ABCD, 32'h0000_0FF0, 3'd0,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         3'd0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0001_ABCD, 32'h0000_0FF0, 3'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'h0000_0FEF, 3'd0,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'h0000_0FEF, 3'd0,   1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0001_ABCD, 3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_0000, 32'h0000_0FF0, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 32'h0000_0000, 32'h0000_0FEF, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 32'h0,         3'd0);
    // Push int at 1 wraps its flags word to 0xFFF; Pop int at 0xFFF wraps up through 0
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h8000_C0DE, 32'h0000_0001, 3'b101, (i < 2), 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd0);
    for (int i = 0; i < 3; i++)
      add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 32'h0000_0000, 32'h0000_0FFF, 3'd0, (i < 2), 1'b0, (i == 2), (i == 2), 16'h0000, 32'h8000_C0DE, 3'b101);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h0000_0000, 32'h0000_0FFF, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h0000_0000, 32'h0000_0000, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'hC0DE, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h0000_0000, 32'h0000_0001, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h8000, 32'h0,         3'd0);
    // Flags-only push/pop, then an idle cycle to see the pulse drop
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_0000, 32'h0000_0100, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         3'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0000, 32'h0000_0100, 3'd0,   1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,         3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000, 3'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         3'd0);
`ifndef MEM_STAGE_ADDR_CHECK_EN
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h0000_0000, 32'h0001_0005, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0,         3'd0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset.stall", {31'd0, bus.Stall}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during W2 of a Push int: third word (at A-2) must not be written
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_1111, 32'h0000_01FE, 3'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd0);
    apply_vec(vecs[vecs.size()-1], "rst.pre");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h2222_3333, 32'h0000_0200, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd0);
    apply_vec(vecs[vecs.size()-1], "rst.w1");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rst.mid");
    rst_n = 1'b1;
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h0000_0000, 32'h0000_01FE, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 32'h0, 3'd0);
    apply_vec(vecs[vecs.size()-1], "rst.word3");
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_0000, 32'h0000_0200, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 32'h0, 3'd0);
    apply_vec(vecs[vecs.size()-1], "rst.word1");

`ifdef MEM_STAGE_ADDR_CHECK_EN
    // Out-of-range store and push: fault pulse, no write, no stall
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_9999, 32'h0001_0000, 3'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd0);
    apply_vec(vecs[vecs.size()-1], "flt.store");
    chk("flt.store.fault", {31'd0, bus.Mem_Fault}, 32'd1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h0000_0000, 32'h0000_0000, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'hC0DE, 32'h0, 3'd0);
    apply_vec(vecs[vecs.size()-1], "flt.mem");
    chk("flt.mem.fault", {31'd0, bus.Mem_Fault}, 32'd0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h5555_6666, 32'h0001_0010, 3'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd0);
    apply_vec(vecs[vecs.size()-1], "flt.push");
    chk("flt.push.fault", {31'd0, bus.Mem_Fault}, 32'd1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h0000_0000, 32'h0000_0010, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd0);
    v = vecs[vecs.size()-1];
    bus.MW = 1'b1; bus.MR = 1'b0; bus.Data = 32'h0000_0000; bus.Address = 32'h0000_0010; bus.WB = 1'b0;
    @(posedge clk);
    #1;
    apply_vec(v, "flt.push.mem");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
